mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Parametrised memory-access pipeline stage between EX/MEM and MEM/WB. It performs RISC-V byte/halfword/word loads and stores selected by FUNCT3, with sign or zero extension. A configurable memory latency stalls the upstream pipeline, and the stage resolves the conditional branch decision. Unlike the single-cycle word-only stage it replaces, it registers its MEM/WB outputs, reports access faults, and holds upstream with a stall handshake.

## Interface
Parameters:
- XLEN, 32, data/address width.
- DEPTH_WORDS, 256, data memory size in XLEN-bit words; power of two.
- MEM_LATENCY, 2, cycles from load/store acceptance to WB output; must be ≥1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- VALID_MEM  in  1  instruction present in MEM.
- ALU_OUT_MEM  in  XLEN  address or ALU result; bit 0 carries the SLT result for branches.
- ZERO_MEM  in  1  ALU zero flag.
- PC_MEM  in  XLEN  instruction PC.
- REG_DATA2_MEM  in  XLEN  store data.
- RD_MEM  in  5  destination register.
- FUNCT3_MEM  in  3  access size / branch condition.
- RegWrite_MEM, MemtoReg_MEM, MemRead_MEM, MemWrite_MEM, Branch_MEM  in  1 each  control bits.
- STALL_MEM  out  1  upstream must hold all inputs stable while high (combinational).
- PCSrc_MEM  out  1  branch taken (combinational).
- VALID_WB  out  1  registered instruction valid.
- PC_WB, ALU_OUT_WB, DATA_MEMORY_WB  out  XLEN  registered PC, ALU result, extended load data.
- RD_WB  out  5;  RegWrite_WB, MemtoReg_WB  out  1  registered.
- FAULT_WB  out  1  registered access fault.

## Operation
- Non-memory instruction (VALID_MEM, neither MemRead nor MemWrite) is registered into the WB outputs in one cycle with no stall. DATA_MEMORY_WB is 0.
- Word index is ALU_OUT_MEM[log2(DEPTH_WORDS)+1:2]; the byte offset is [1:0]. Upper address bits are ignored, so addresses wrap.
- Loads: FUNCT3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. The selected lane is right-aligned, then sign- or zero-extended.
- Stores: 000 SB, 001 SH, 010 SW. Byte enables are derived from the offset; the unselected bytes are preserved.
- Fault conditions: halfword with addr[0]=1; word with addr[1:0]≠0; an undefined FUNCT3 for the direction; MemRead and MemWrite both high.
- On a fault: no memory access, no stall. FAULT_WB=1 and VALID_WB=1 for one cycle, with RegWrite_WB forced 0.
- FSM states are IDLE and WAIT, with a counter CNT.
  - IDLE: a valid, non-faulting memory operation is accepted.
  - If MEM_LATENCY=1, it completes at this edge.
  - Otherwise the FSM goes to WAIT with CNT=MEM_LATENCY-2.
  - WAIT: CNT decrements. When CNT=0, the operation completes at that edge and the FSM returns to IDLE.
- STALL_MEM = (IDLE and accepting with MEM_LATENCY>1) or (WAIT and CNT≠0).
- Completion edge: the store writes the array, load data is sampled, and the WB registers load.
- Branch decision: PCSrc_MEM = VALID_MEM & Branch_MEM & cond. The condition by FUNCT3 is:
  - 000: ZERO.
  - 001: !ZERO.
  - 100/110: ALU_OUT[0].
  - 101/111: !ALU_OUT[0].
  - 010/011: 0.
- A cycle with no valid instruction (VALID_MEM=0) loads VALID_WB=0 and RegWrite_WB=0.

## Timing
- Reset sets all registered outputs to 0, the FSM to IDLE and CNT to 0. Memory array contents are unaffected by reset.
- Reset asserted mid-WAIT aborts the operation: the store is not committed and STALL_MEM drops in the following cycle. Reset has priority over completion.
- A load/store accepted in cycle t:
  - STALL_MEM is high in cycles t … t+MEM_LATENCY-2.
  - Results are visible on the WB outputs in cycle t+MEM_LATENCY.
- A load immediately after a store to the same word returns the new data, because the write commits before the next acceptance.
- Back-to-back memory operations: the next one is accepted in the cycle after completion, with no bubble beyond the latency.

## Structure
- Package mem_stage_pkg holds:
  - FUNCT3 load/store/branch localparams.
  - The state enum (IDLE, WAIT).
  - The fault-check and extension functions.
- One sub-module, byte_ram: DEPTH_WORDS×XLEN array with a synchronous byte-enabled write, a combinational read, and no reset.

## Test plan
- MEM_LATENCY=2: SW 0xDEADBEEF at address 0x10, then LW 0x10. Required: STALL_MEM high for 1 cycle per operation; DATA_MEMORY_WB=0xDEADBEEF two cycles after acceptance.
- Follow with LB 0x13 → 0xFFFFFFDE, LBU 0x13 → 0x000000DE, LH 0x12 → 0xFFFFDEAD. Then SB 0x55 at 0x11 and LW 0x10 → 0xDEAD55EF.
- LH at 0x11 and LW at 0x12. Required: no stall, FAULT_WB=1, RegWrite_WB=0, and memory unchanged.
- BNE with ZERO_MEM=0 → PCSrc_MEM=1. BGE with ALU_OUT[0]=1 → 0. FUNCT3=010 → 0. VALID_MEM=0 → 0.
- Reset asserted during WAIT of an SW to 0x20 (MEM_LATENCY=4). Required: all outputs 0 next cycle, FSM IDLE, and a later LW 0x20 returns the old value.
- MEM_LATENCY=1 and DEPTH_WORDS=16: SW to 0x40 wraps to word 0, and LW 0x0 returns it. STALL_MEM is never asserted.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared FUNCT3 encodings, FSM state type and access helpers for the MEM stage LSU.
package mem_stage_pkg;

    localparam logic [2:0] F3_B    = 3'b000;
    localparam logic [2:0] F3_H    = 3'b001;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_BU   = 3'b100;
    localparam logic [2:0] F3_HU   = 3'b101;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {IDLE, WAIT} state_t;

    // Misalignment, undefined size for the direction, or conflicting read+write.
    function automatic logic access_fault(input logic [2:0] f3, input logic rd,
                                          input logic wr, input logic [1:0] off);
        logic bad_f3;
        logic misalign;
        if (rd) bad_f3 = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        else    bad_f3 = !(f3 inside {F3_B, F3_H, F3_W});
        misalign = ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
        return (rd && wr) || bad_f3 || misalign;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] word,
                                                input logic [1:0] off);
        logic [31:0] s;
        s = word >> {off, 3'b000};
        case (f3)
            F3_B:    return {{24{s[7]}}, s[7:0]};
            F3_H:    return {{16{s[15]}}, s[15:0]};
            F3_BU:   return {24'd0, s[7:0]};
            F3_HU:   return {16'd0, s[15:0]};
            default: return s;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B:    return 4'b0001 << off;
            F3_H:    return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the store lane so every byte position carries the selected data.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_B:    return {4{d[7:0]}};
            F3_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/byte_ram.sv
// Word-organised data memory: byte-enabled synchronous write, combinational read, no reset.
module byte_ram #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_W      = 8
) (
    input  logic                clk,
    input  logic                we,
    input  logic [XLEN/8-1:0]   be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [XLEN-1:0]     wdata,
    output logic [XLEN-1:0]     rdata
);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < XLEN / 8; b++) begin
                if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: sized loads/stores with fixed latency, stall handshake,
// access-fault reporting, branch resolution and registered MEM/WB outputs.
module mem_stage_lsu
    import mem_stage_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             VALID_MEM,
    input  logic [XLEN-1:0]  ALU_OUT_MEM,
    input  logic             ZERO_MEM,
    input  logic [XLEN-1:0]  PC_MEM,
    input  logic [XLEN-1:0]  REG_DATA2_MEM,
    input  logic [4:0]       RD_MEM,
    input  logic [2:0]       FUNCT3_MEM,
    input  logic             RegWrite_MEM,
    input  logic             MemtoReg_MEM,
    input  logic             MemRead_MEM,
    input  logic             MemWrite_MEM,
    input  logic             Branch_MEM,
    output logic             STALL_MEM,
    output logic             PCSrc_MEM,
    output logic             VALID_WB,
    output logic [XLEN-1:0]  PC_WB,
    output logic [XLEN-1:0]  ALU_OUT_WB,
    output logic [XLEN-1:0]  DATA_MEMORY_WB,
    output logic [4:0]       RD_WB,
    output logic             RegWrite_WB,
    output logic             MemtoReg_WB,
    output logic             FAULT_WB
);

    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam int unsigned CW    = $clog2(MEM_LATENCY + 1);
    localparam int unsigned BE_W  = XLEN / 8;
    localparam logic        MULTI = (MEM_LATENCY > 1);

    state_t          state;
    logic [CW-1:0]   cnt;

    logic            is_mem_c;
    logic            fault_c;
    logic            accept_c;
    logic            complete_c;
    logic            wb_take_c;
    logic            we_c;
    logic [1:0]      off_c;
    logic [XLEN-1:0] rdata_c;
    logic            cond_c;

    assign off_c      = ALU_OUT_MEM[1:0];
    assign is_mem_c   = MemRead_MEM || MemWrite_MEM;
    assign fault_c    = (state == IDLE) && VALID_MEM && is_mem_c &&
                        access_fault(FUNCT3_MEM, MemRead_MEM, MemWrite_MEM, off_c);
    assign accept_c   = (state == IDLE) && VALID_MEM && is_mem_c && !fault_c;
    assign complete_c = (accept_c && !MULTI) || ((state == WAIT) && (cnt == '0));
    assign wb_take_c  = ((state == IDLE) && VALID_MEM && (!is_mem_c || fault_c)) || complete_c;
    // Reset wins over a completing store so an aborted write never lands.
    assign we_c       = complete_c && MemWrite_MEM && !reset;
    assign STALL_MEM  = (accept_c && MULTI) || ((state == WAIT) && (cnt != '0));

    byte_ram #(
        .XLEN        (XLEN),
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (AW)
    ) u_ram (
        .clk   (clk),
        .we    (we_c),
        .be    (BE_W'(store_be(FUNCT3_MEM, off_c))),
        .addr  (ALU_OUT_MEM[AW+1:2]),
        .wdata (XLEN'(store_data(FUNCT3_MEM, REG_DATA2_MEM[31:0]))),
        .rdata (rdata_c)
    );

    // Branch condition; ALU_OUT bit 0 holds the set-less-than result.
    always_comb begin
        cond_c = 1'b0;
        case (FUNCT3_MEM)
            F3_BEQ:            cond_c = ZERO_MEM;
            F3_BNE:            cond_c = !ZERO_MEM;
            F3_BLT, F3_BLTU:   cond_c = ALU_OUT_MEM[0];
            F3_BGE, F3_BGEU:   cond_c = !ALU_OUT_MEM[0];
            default:           cond_c = 1'b0;
        endcase
    end

    assign PCSrc_MEM = VALID_MEM && Branch_MEM && cond_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            VALID_WB       <= 1'b0;
            PC_WB          <= '0;
            ALU_OUT_WB     <= '0;
            DATA_MEMORY_WB <= '0;
            RD_WB          <= '0;
            RegWrite_WB    <= 1'b0;
            MemtoReg_WB    <= 1'b0;
            FAULT_WB       <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (accept_c && MULTI) begin
                    state <= WAIT;
                    cnt   <= CW'(MEM_LATENCY - 2);
                end
            end else begin
                if (cnt == '0) state <= IDLE;
                else           cnt   <= cnt - CW'(1);
            end

            if (wb_take_c) begin
                VALID_WB       <= 1'b1;
                PC_WB          <= PC_MEM;
                ALU_OUT_WB     <= ALU_OUT_MEM;
                DATA_MEMORY_WB <= (complete_c && MemRead_MEM)
                                  ? XLEN'(load_extend(FUNCT3_MEM, rdata_c[31:0], off_c)) : '0;
                RD_WB          <= RD_MEM;
                RegWrite_WB    <= RegWrite_MEM && !fault_c;
                MemtoReg_WB    <= MemtoReg_MEM;
                FAULT_WB       <= fault_c;
            end else begin
                VALID_WB       <= 1'b0;
                RegWrite_WB    <= 1'b0;
                FAULT_WB       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: three instances (latency 2, latency 4, latency 1 / 16 words).
module tb_mem_stage_lsu;

    typedef struct {
        string       nm;
        bit          rd;
        bit          wr;
        bit          rw;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] want;
        bit          flt;
        int          st;
    } vec_t;

    typedef struct {
        logic [2:0] f3;
        logic       zero;
        logic       a0;
        logic       v;
        logic       want;
    } br_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        valid;
    logic [1:0]  sel;
    logic [2:0]  vsel;
    logic [31:0] alu, pc, wd;
    logic        zero, rw, mtr, mr, mw, br;
    logic [4:0]  rdn;
    logic [2:0]  f3;

    logic        stall [3];
    logic        pcsrc [3];
    logic        vwb   [3];
    logic [31:0] pcwb  [3];
    logic [31:0] aluwb [3];
    logic [31:0] dwb   [3];
    logic [4:0]  rdwb  [3];
    logic        rwwb  [3];
    logic        mtrwb [3];
    logic        fwb   [3];

    int total = 0;
    int bad   = 0;
    int stall2_hi = 0;

    always_comb begin
        for (int k = 0; k < 3; k++) vsel[k] = valid && (sel == 2'(k));
    end

    for (genvar k = 0; k < 3; k++) begin : g_dut
        mem_stage_lsu #(
            .XLEN        (32),
            .DEPTH_WORDS ((k == 2) ? 16 : 256),
            .MEM_LATENCY ((k == 0) ? 2 : ((k == 1) ? 4 : 1))
        ) dut (
            .clk            (clk),
            .reset          (reset),
            .VALID_MEM      (vsel[k]),
            .ALU_OUT_MEM    (alu),
            .ZERO_MEM       (zero),
            .PC_MEM         (pc),
            .REG_DATA2_MEM  (wd),
            .RD_MEM         (rdn),
            .FUNCT3_MEM     (f3),
            .RegWrite_MEM   (rw),
            .MemtoReg_MEM   (mtr),
            .MemRead_MEM    (mr),
            .MemWrite_MEM   (mw),
            .Branch_MEM     (br),
            .STALL_MEM      (stall[k]),
            .PCSrc_MEM      (pcsrc[k]),
            .VALID_WB       (vwb[k]),
            .PC_WB          (pcwb[k]),
            .ALU_OUT_WB     (aluwb[k]),
            .DATA_MEMORY_WB (dwb[k]),
            .RD_WB          (rdwb[k]),
            .RegWrite_WB    (rwwb[k]),
            .MemtoReg_WB    (mtrwb[k]),
            .FAULT_WB       (fwb[k])
        );
    end

    always @(negedge clk) begin
        if (!reset && stall[2]) stall2_hi++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    function automatic vec_t mk(input string nm, input bit r, input bit w, input logic [2:0] f,
                                input logic [31:0] a, input logic [31:0] d, input logic [31:0] e,
                                input bit flt, input int st);
        vec_t v;
        v.nm = nm; v.rd = r; v.wr = w; v.rw = r || !w; v.f3 = f;
        v.addr = a; v.wd = d; v.want = e; v.flt = flt; v.st = st;
        return v;
    endfunction

    task automatic idle_inputs();
        valid = 1'b0; mr = 1'b0; mw = 1'b0; br = 1'b0; rw = 1'b0; mtr = 1'b0;
    endtask

    // Present one instruction, hold it while stalled, then check the WB result.
    task automatic mem_op(input int k, input vec_t v);
        int n;
        @(posedge clk); #1;
        sel = 2'(k); valid = 1'b1; mr = v.rd; mw = v.wr; f3 = v.f3; alu = v.addr;
        wd = v.wd; rw = v.rw; mtr = v.rd; br = 1'b0; pc = 32'h100 + v.addr; rdn = 5'd9;
        #1;
        n = 0;
        while (stall[k] && n < 20) begin
            n++;
            @(posedge clk); #2;
        end
        chk({v.nm, " stall_cycles"}, 32'(n), 32'(v.st));
        @(posedge clk); #1;
        idle_inputs();
        chk({v.nm, " valid_wb"}, 32'(vwb[k]), 32'd1);
        chk({v.nm, " fault_wb"}, 32'(fwb[k]), 32'(v.flt));
        chk({v.nm, " regwrite_wb"}, 32'(rwwb[k]), 32'(v.rw && !v.flt));
        chk({v.nm, " alu_wb"}, aluwb[k], v.addr);
        chk({v.nm, " rd_wb"}, 32'(rdwb[k]), 32'd9);
        if (v.rd && !v.wr && !v.flt) chk({v.nm, " data_wb"}, dwb[k], v.want);
        if (!v.rd && !v.wr)          chk({v.nm, " data_wb_nonmem"}, dwb[k], 32'd0);
    endtask

    task automatic chk_zero(input int k, input string tag);
        chk({tag, " stall"},    32'(stall[k]), 32'd0);
        chk({tag, " valid_wb"}, 32'(vwb[k]),   32'd0);
        chk({tag, " flags_wb"}, 32'({fwb[k], rwwb[k], mtrwb[k]}), 32'd0);
        chk({tag, " data_wb"},  dwb[k],   32'd0);
        chk({tag, " alu_wb"},   aluwb[k], 32'd0);
        chk({tag, " pc_wb"},    pcwb[k],  32'd0);
        chk({tag, " rd_wb"},    32'(rdwb[k]), 32'd0);
    endtask

    // Start an SW on the latency-4 instance and let it sit for `wait_cycles` edges.
    task automatic sw_then_reset(input logic [31:0] a, input logic [31:0] d,
                                 input int wait_cycles, input logic want_stall, input string tag);
        @(posedge clk); #1;
        sel = 2'd1; valid = 1'b1; mr = 1'b0; mw = 1'b1; f3 = 3'b010; alu = a; wd = d;
        rw = 1'b0; mtr = 1'b0; br = 1'b0; pc = 32'h200;
        #1;
        chk({tag, " accept_stall"}, 32'(stall[1]), 32'd1);
        repeat (wait_cycles) @(posedge clk);
        #1;
        chk({tag, " wait_stall"}, 32'(stall[1]), 32'(want_stall));
        reset = 1'b1;
        valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_zero(1, tag);
    endtask

    vec_t vt [22];
    br_t  bt [10];

    initial begin
        vt[0]  = mk("sw_10",       0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, 1);
        vt[1]  = mk("lw_10",       1, 0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0, 1);
        vt[2]  = mk("lb_13",       1, 0, 3'b000, 32'h13, 32'h0,        32'hFFFFFFDE, 0, 1);
        vt[3]  = mk("lbu_13",      1, 0, 3'b100, 32'h13, 32'h0,        32'h000000DE, 0, 1);
        vt[4]  = mk("lh_12",       1, 0, 3'b001, 32'h12, 32'h0,        32'hFFFFDEAD, 0, 1);
        vt[5]  = mk("sb_11",       0, 1, 3'b000, 32'h11, 32'hAAAAAA55, 32'h0,        0, 1);
        vt[6]  = mk("lw_10_sb",    1, 0, 3'b010, 32'h10, 32'h0,        32'hDEAD55EF, 0, 1);
        vt[7]  = mk("lh_11_mis",   1, 0, 3'b001, 32'h11, 32'h0,        32'h0,        1, 0);
        vt[8]  = mk("lw_12_mis",   1, 0, 3'b010, 32'h12, 32'h0,        32'h0,        1, 0);
        vt[9]  = mk("sw_12_mis",   0, 1, 3'b010, 32'h12, 32'h11111111, 32'h0,        1, 0);
        vt[10] = mk("sh_13_mis",   0, 1, 3'b001, 32'h13, 32'h22222222, 32'h0,        1, 0);
        vt[11] = mk("ld_f3_011",   1, 0, 3'b011, 32'h10, 32'h0,        32'h0,        1, 0);
        vt[12] = mk("st_f3_100",   0, 1, 3'b100, 32'h10, 32'h33333333, 32'h0,        1, 0);
        vt[13] = mk("rd_and_wr",   1, 1, 3'b010, 32'h10, 32'h44444444, 32'h0,        1, 0);
        vt[14] = mk("lw_10_after", 1, 0, 3'b010, 32'h10, 32'h0,        32'hDEAD55EF, 0, 1);
        vt[15] = mk("sh_12",       0, 1, 3'b001, 32'h12, 32'h77778001, 32'h0,        0, 1);
        vt[16] = mk("lw_10_sh",    1, 0, 3'b010, 32'h10, 32'h0,        32'h800155EF, 0, 1);
        vt[17] = mk("lh_12_neg",   1, 0, 3'b001, 32'h12, 32'h0,        32'hFFFF8001, 0, 1);
        vt[18] = mk("lhu_12",      1, 0, 3'b101, 32'h12, 32'h0,        32'h00008001, 0, 1);
        vt[19] = mk("lb_10",       1, 0, 3'b000, 32'h10, 32'h0,        32'hFFFFFFEF, 0, 1);
        vt[20] = mk("alu_op",      0, 0, 3'b000, 32'h1234, 32'h0,      32'h0,        0, 0);
        vt[21] = mk("lhu_10",      1, 0, 3'b101, 32'h10, 32'h0,        32'h000055EF, 0, 1);

        bt[0] = '{3'b000, 1'b1, 1'b0, 1'b1, 1'b1};
        bt[1] = '{3'b001, 1'b0, 1'b0, 1'b1, 1'b1};
        bt[2] = '{3'b001, 1'b1, 1'b0, 1'b1, 1'b0};
        bt[3] = '{3'b100, 1'b0, 1'b1, 1'b1, 1'b1};
        bt[4] = '{3'b101, 1'b0, 1'b1, 1'b1, 1'b0};
        bt[5] = '{3'b111, 1'b0, 1'b0, 1'b1, 1'b1};
        bt[6] = '{3'b110, 1'b0, 1'b0, 1'b1, 1'b0};
        bt[7] = '{3'b010, 1'b1, 1'b1, 1'b1, 1'b0};
        bt[8] = '{3'b011, 1'b1, 1'b1, 1'b1, 1'b0};
        bt[9] = '{3'b000, 1'b1, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; sel = 2'd0; alu = '0; pc = '0; wd = '0; zero = 1'b0;
        rdn = '0; f3 = '0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk_zero(0, "reset_state");
        reset = 1'b0;

        for (int i = 0; i < 22; i++) mem_op(0, vt[i]);

        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            sel = 2'd0; valid = bt[i].v; br = 1'b1; mr = 1'b0; mw = 1'b0; rw = 1'b0;
            f3 = bt[i].f3; zero = bt[i].zero; alu = {31'd0, bt[i].a0};
            #1;
            chk($sformatf("branch_%0d", i), 32'(pcsrc[0]), 32'(bt[i].want));
        end
        @(posedge clk); #1;
        idle_inputs();

        mem_op(1, mk("l4_sw_20", 0, 1, 3'b010, 32'h20, 32'h12345678, 32'h0, 0, 3));
        sw_then_reset(32'h20, 32'hCAFEF00D, 1, 1'b1, "abort_mid");
        sw_then_reset(32'h20, 32'h0BADF00D, 3, 1'b0, "abort_last");
        mem_op(1, mk("l4_lw_20", 1, 0, 3'b010, 32'h20, 32'h0, 32'h12345678, 0, 3));

        mem_op(2, mk("l1_sw_40", 0, 1, 3'b010, 32'h40, 32'hA5A55A5A, 32'h0, 0, 0));
        mem_op(2, mk("l1_lw_00", 1, 0, 3'b010, 32'h00, 32'h0, 32'hA5A55A5A, 0, 0));
        mem_op(2, mk("l1_lb_03", 1, 0, 3'b000, 32'h03, 32'h0, 32'hFFFFFFA5, 0, 0));
        mem_op(2, mk("l1_lw_40", 1, 0, 3'b010, 32'h40, 32'h0, 32'hA5A55A5A, 0, 0));
        @(posedge clk); #1;
        chk("l1_stall_never", 32'(stall2_hi), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
